// File: rtl/fifo_write_byte_packer.sv
// Packs a valid/ready byte stream little-endian into DATA_WIDTH-bit words and
// writes them to a FIFO write port, reporting each packet's byte length.
module fifo_write_byte_packer #(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic [7:0]            s_tdata,
   input  logic                  s_tvalid,
   input  logic                  s_tlast,
   output logic                  s_tready,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_en,
   input  logic                  full,
   output logic                  pkt_done,
   output logic [LEN_WIDTH-1:0]  pkt_len,
   output logic [31:0]           words_written
);
   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int LANE_W = $clog2(BYTES);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

   logic [DATA_WIDTH-1:0] acc_p0;
   logic [LANE_W-1:0]     lane_p0;
   logic [LEN_WIDTH-1:0]  cnt_p0;

   logic                  vld_p1;
   logic [DATA_WIDTH-1:0] data_p1;
   logic                  last_p1;
   logic [LEN_WIDTH-1:0]  len_p1;

   logic                  accept;
   logic                  close;
   logic [DATA_WIDTH-1:0] word;

   function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // A word can only close while the output register is empty or draining.
   assign s_tready = ~vld_p1 | ~full;
   assign accept   = s_tvalid & s_tready;
   assign close    = accept & (s_tlast | (lane_p0 == LAST_LANE));

   assign wr_en    = vld_p1 & ~full;
   assign wr_data  = data_p1;
   assign pkt_done = wr_en & last_p1;
   assign pkt_len  = len_p1;

   always_comb begin
      word = acc_p0;
      for (int i = 0; i < BYTES; i++) begin
         if (LANE_W'(i) == lane_p0)
            word[8*i +: 8] = s_tdata;
         else if (LANE_W'(i) > lane_p0)
            word[8*i +: 8] = 8'h00;
      end
   end

   // Stage 0: byte accumulator, lane index and packet byte counter
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         acc_p0  <= '0;
         lane_p0 <= '0;
         cnt_p0  <= '0;
      end else if (accept) begin
         if (close) begin
            acc_p0  <= '0;
            lane_p0 <= '0;
         end else begin
            acc_p0  <= word;
            lane_p0 <= lane_p0 + 1'b1;
         end
         cnt_p0 <= s_tlast ? '0 : sat_inc(cnt_p0);
      end
   end

   // Stage 1: single-entry output register feeding the FIFO write port
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         vld_p1        <= 1'b0;
         data_p1       <= '0;
         last_p1       <= 1'b0;
         len_p1        <= '0;
         words_written <= '0;
      end else begin
         if (close) begin
            vld_p1  <= 1'b1;
            data_p1 <= word;
            last_p1 <= s_tlast;
         end else if (wr_en) begin
            vld_p1 <= 1'b0;
         end
         if (accept & s_tlast)
            len_p1 <= sat_inc(cnt_p0);
         if (wr_en)
            words_written <= words_written + 32'd1;
      end
   end
endmodule

// File: tb/tb_fifo_write_byte_packer.sv
// Directed bench for fifo_write_byte_packer (DATA_WIDTH=32, LEN_WIDTH=16).
module tb_fifo_write_byte_packer;
   logic        clock = 1'b0;
   logic        resetn;
   logic [7:0]  s_tdata;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tready;
   logic [31:0] wr_data;
   logic        wr_en;
   logic        full;
   logic        pkt_done;
   logic [15:0] pkt_len;
   logic [31:0] words_written;

   int tests = 0;
   int fails = 0;
   int acc_cnt = 0;
   int wr_full_cnt = 0;
   logic [31:0] wq[$];
   logic        dq[$];
   logic [15:0] lq[$];

   fifo_write_byte_packer #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
      .clock(clock), .resetn(resetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
      .s_tlast(s_tlast), .s_tready(s_tready), .wr_data(wr_data), .wr_en(wr_en),
      .full(full), .pkt_done(pkt_done), .pkt_len(pkt_len), .words_written(words_written)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (wr_en) begin
         wq.push_back(wr_data);
         dq.push_back(pkt_done);
         if (pkt_done) lq.push_back(pkt_len);
         if (full) wr_full_cnt++;
      end
   end

   task automatic clear_q();
      wq.delete(); dq.delete(); lq.delete();
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      int t = 0;
      s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
      @(negedge clock);
      while (!s_tready && t < 100) begin @(negedge clock); t++; end
      if (t >= 100) begin
         tests++; fails++;
         $display("FAIL send_timeout byte %h: s_tready stayed %b, required 1", d, s_tready);
      end
      @(posedge clock); #1;
      acc_cnt++;
   endtask

   task automatic send_pkt(input logic [7:0] start, input int n);
      for (int i = 0; i < n; i++) send_byte(start + 8'(i), i == n - 1);
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic drain();
      repeat (4) @(negedge clock);
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; full = 1'b0;
      #1;
      tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL rst_tready got %b want 1", s_tready); end
      tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en got %b want 0", wr_en); end
      tests++; if (wr_data !== 32'h0) begin fails++; $display("FAIL rst_wr_data got %h want 0", wr_data); end
      tests++; if (pkt_done !== 1'b0) begin fails++; $display("FAIL rst_pkt_done got %b want 0", pkt_done); end
      tests++; if (pkt_len !== 16'h0) begin fails++; $display("FAIL rst_pkt_len got %0d want 0", pkt_len); end
      tests++; if (words_written !== 32'h0) begin fails++; $display("FAIL rst_words got %0d want 0", words_written); end
      repeat (2) @(posedge clock); #1;
      resetn = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_full_words();
      clear_q();
      send_pkt(8'h01, 8);
      drain();
      tests++; if (wq.size() !== 2) begin fails++; $display("FAIL w8_count got %0d want 2", wq.size()); end
      tests++; if (wq[0] !== 32'h04030201) begin fails++; $display("FAIL w8_word0 got %h want 04030201", wq[0]); end
      tests++; if (wq[1] !== 32'h08070605) begin fails++; $display("FAIL w8_word1 got %h want 08070605", wq[1]); end
      tests++; if (dq[0] !== 1'b0 || dq[1] !== 1'b1) begin fails++; $display("FAIL w8_done got %b%b want 01", dq[0], dq[1]); end
      tests++; if (lq[0] !== 16'd8) begin fails++; $display("FAIL w8_len got %0d want 8", lq[0]); end
      tests++; if (words_written !== 32'd2) begin fails++; $display("FAIL w8_words got %0d want 2", words_written); end
   endtask

   task automatic test_partial_word();
      clear_q();
      send_pkt(8'hA0, 5);
      drain();
      tests++; if (wq.size() !== 2) begin fails++; $display("FAIL p5_count got %0d want 2", wq.size()); end
      tests++; if (wq[0] !== 32'hA3A2A1A0) begin fails++; $display("FAIL p5_word0 got %h want a3a2a1a0", wq[0]); end
      tests++; if (wq[1] !== 32'h000000A4) begin fails++; $display("FAIL p5_word1 got %h want 000000a4", wq[1]); end
      tests++; if (dq[1] !== 1'b1 || lq[0] !== 16'd5) begin fails++; $display("FAIL p5_len got done=%b len=%0d want done=1 len=5", dq[1], lq[0]); end
      tests++; if (words_written !== 32'd4) begin fails++; $display("FAIL p5_words got %0d want 4", words_written); end
   endtask

   task automatic test_single_byte();
      clear_q();
      send_pkt(8'h55, 1);
      @(negedge clock);
      tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL b1_latency wr_en got %b want 1", wr_en); end
      tests++; if (wr_data !== 32'h00000055) begin fails++; $display("FAIL b1_data got %h want 00000055", wr_data); end
      tests++; if (pkt_done !== 1'b1 || pkt_len !== 16'd1) begin fails++; $display("FAIL b1_done got done=%b len=%0d want done=1 len=1", pkt_done, pkt_len); end
      drain();
      tests++; if (wq.size() !== 1) begin fails++; $display("FAIL b1_count got %0d want 1", wq.size()); end
      tests++; if (words_written !== 32'd5) begin fails++; $display("FAIL b1_words got %0d want 5", words_written); end
   endtask

   task automatic test_stall();
      clear_q();
      acc_cnt = 0;
      wr_full_cnt = 0;
      fork
         send_pkt(8'h21, 12);
         begin
            wait (acc_cnt == 4);
            @(posedge clock); #1;
            full = 1'b1;
            repeat (9) @(posedge clock);
            @(negedge clock);
            tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL stall_tready got %b want 0", s_tready); end
            tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL stall_wr_en got %b want 0", wr_en); end
            tests++; if (wq.size() !== 1) begin fails++; $display("FAIL stall_early_count got %0d want 1", wq.size()); end
            @(posedge clock); #1;
            full = 1'b0;
         end
      join
      drain();
      tests++; if (wr_full_cnt !== 0) begin fails++; $display("FAIL stall_write_while_full got %0d want 0", wr_full_cnt); end
      tests++; if (wq.size() !== 3) begin fails++; $display("FAIL stall_count got %0d want 3", wq.size()); end
      tests++; if (wq[0] !== 32'h24232221 || wq[1] !== 32'h28272625 || wq[2] !== 32'h2C2B2A29) begin
         fails++; $display("FAIL stall_order got %h %h %h want 24232221 28272625 2c2b2a29", wq[0], wq[1], wq[2]);
      end
      tests++; if (lq.size() !== 1 || lq[0] !== 16'd12) begin fails++; $display("FAIL stall_len got n=%0d len=%0d want n=1 len=12", lq.size(), lq[0]); end
      tests++; if (words_written !== 32'd8) begin fails++; $display("FAIL stall_words got %0d want 8", words_written); end
   endtask

   task automatic test_back_to_back();
      clear_q();
      send_pkt(8'h01, 3);
      send_pkt(8'h0A, 6);
      drain();
      tests++; if (wq.size() !== 3) begin fails++; $display("FAIL b2b_count got %0d want 3", wq.size()); end
      tests++; if (wq[0] !== 32'h00030201 || wq[1] !== 32'h0D0C0B0A || wq[2] !== 32'h00000F0E) begin
         fails++; $display("FAIL b2b_words got %h %h %h want 00030201 0d0c0b0a 00000f0e", wq[0], wq[1], wq[2]);
      end
      tests++; if (dq[0] !== 1'b1 || dq[1] !== 1'b0 || dq[2] !== 1'b1) begin fails++; $display("FAIL b2b_done got %b%b%b want 101", dq[0], dq[1], dq[2]); end
      tests++; if (lq[0] !== 16'd3 || lq[1] !== 16'd6) begin fails++; $display("FAIL b2b_len got %0d %0d want 3 6", lq[0], lq[1]); end
      tests++; if (words_written !== 32'd11) begin fails++; $display("FAIL b2b_words got %0d want 11", words_written); end
   endtask

   task automatic test_mid_reset();
      clear_q();
      send_byte(8'hE1, 1'b0);
      send_byte(8'hE2, 1'b0);
      s_tvalid = 1'b0;
      resetn = 1'b0;
      #1;
      tests++; if (s_tready !== 1'b1 || wr_en !== 1'b0 || pkt_done !== 1'b0) begin
         fails++; $display("FAIL mrst_ctrl got tready=%b wr_en=%b done=%b want 1 0 0", s_tready, wr_en, pkt_done);
      end
      tests++; if (words_written !== 32'd0 || wr_data !== 32'h0 || pkt_len !== 16'h0) begin
         fails++; $display("FAIL mrst_vals got words=%0d data=%h len=%0d want 0 0 0", words_written, wr_data, pkt_len);
      end
      repeat (2) @(posedge clock); #1;
      resetn = 1'b1;
      drain();
      tests++; if (wq.size() !== 0) begin fails++; $display("FAIL mrst_discard got %0d writes want 0", wq.size()); end
      send_pkt(8'h11, 4);
      drain();
      tests++; if (wq.size() !== 1 || wq[0] !== 32'h14131211) begin fails++; $display("FAIL mrst_word got n=%0d %h want n=1 14131211", wq.size(), wq[0]); end
      tests++; if (lq[0] !== 16'd4) begin fails++; $display("FAIL mrst_len got %0d want 4", lq[0]); end
      tests++; if (words_written !== 32'd1) begin fails++; $display("FAIL mrst_words got %0d want 1", words_written); end
   endtask

   initial begin
      test_reset();
      test_full_words();
      test_partial_word();
      test_single_byte();
      test_stall();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fifo_write_byte_packer.md
# fifo_write_byte_packer

Byte-stream-to-word packer that drives the write side of a packet FIFO. It accepts one byte per cycle over a valid/ready stream with an end-of-packet marker, assembles the bytes little-endian into DATA_WIDTH-bit words, and writes them to the FIFO's write port while honouring `full`. It sits directly upstream of the FIFO write interface in the SP receive path and reports the length of each completed packet.

## Interface
- `DATA_WIDTH`, default 32: FIFO word width. Must be a multiple of 8 and at least 16. BYTES = DATA_WIDTH/8.
- `LEN_WIDTH`, default 16: width of the packet byte counter.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `s_tdata`  in  8  input byte.
- `s_tvalid`  in  1  `s_tdata` and `s_tlast` are valid.
- `s_tlast`  in  1  current byte is the last byte of the packet.
- `s_tready`  out  1  packer accepts the byte this cycle.
- `wr_data`  out  DATA_WIDTH  FIFO write data.
- `wr_en`  out  1  FIFO write strobe, one word per asserted cycle.
- `full`  in  1  FIFO full; no write may occur while it is high.
- `pkt_done`  out  1  one-cycle pulse when the final word of a packet is written.
- `pkt_len`  out  LEN_WIDTH  byte count of that packet; valid while `pkt_done` is high.
- `words_written`  out  32  free-running count of FIFO writes; wraps at 2^32.

## Operation
- A byte is accepted when `s_tvalid & s_tready` is high.
- Accumulator: a DATA_WIDTH-bit register plus a byte-lane index `lane` in 0..BYTES-1. An accepted byte goes to bits `[8*lane+7 : 8*lane]`. The first byte of each packet lands in lane 0.
- A word closes when the accepted byte has `lane == BYTES-1` or has `s_tlast` set. On close:
  - The word moves to the output register, with lanes above the current lane forced to 0.
  - `out_valid` is set.
  - `out_last` takes the value of `s_tlast`.
  - `lane` returns to 0 and the accumulator clears.
- Output register: one entry (`out_valid`, `out_data`, `out_last`, `out_len`).
  - `wr_data = out_data`.
  - `wr_en = out_valid & ~full`. This is combinational from `full`.
  - On `wr_en`, `out_valid` clears unless a new word closes in the same cycle, in which case it stays set with the new contents.
- `s_tready = ~out_valid | ~full`. Consequently, a word only closes when the output register is empty or draining in that cycle, so no word is ever overwritten.
- Byte counter `cnt`:
  - Increments on each accepted byte and saturates at 2^LEN_WIDTH-1.
  - On an accepted `s_tlast` byte, `out_len` captures `cnt+1` (saturated) and `cnt` resets to 0.
- `pkt_done = wr_en & out_last`. `pkt_len = out_len`.
- `words_written` increments on every `wr_en`.
- Reset (`resetn` low): all registers clear immediately.
  - Any partial word and any pending output word are discarded.
  - Outputs: `s_tready`=1 after reset, since `out_valid`=0; `wr_en`=0, `wr_data`=0, `pkt_done`=0, `pkt_len`=0, `words_written`=0.

## Timing
- Throughput is one byte per cycle while `full` is low, and one FIFO write per BYTES accepted bytes.
- Latency: a byte closing a word in cycle N produces `wr_en` in cycle N+1 if `full` is low, otherwise in the first later cycle with `full` low.
- `full` high with `out_valid` set:
  - `s_tready`=0 and `wr_en`=0.
  - Accumulator and output register hold their values.
- `full` high with `out_valid` clear: bytes are still accepted until the next word closes.
- Simultaneous `wr_en` and word close in the same cycle: the new word replaces the drained one and there is no bubble.
- Back-to-back packets: a byte after `s_tlast` may be accepted the very next cycle and starts in lane 0 with `cnt`=0.
- `s_tvalid` low: no state changes except output drain.

## Test plan
- DATA_WIDTH=32, `full`=0, 8-byte packet 0x01..0x08 back-to-back -> `wr_en` twice with 0x04030201 then 0x08070605; `pkt_done` on the second write with `pkt_len`=8; `words_written`=2.
- 5-byte packet 0xA0..0xA4 -> writes 0xA3A2A1A0 then 0x000000A4; `pkt_done` with `pkt_len`=5.
- 1-byte packet 0x55 -> a single write of 0x00000055 one cycle after acceptance, with `pkt_done`=1 and `pkt_len`=1.
- 12-byte packet with `full` forced high for 10 cycles after the first word closes -> during the stall `wr_en` never asserts while `full`=1 and `s_tready` drops once the next word closes; after `full` releases, all three words arrive in order with no loss or duplication.
- Two packets of 3 and 6 bytes with no idle cycle between -> writes 0x00030201 (`pkt_len`=3), then 0x0D0C0B0A and 0x00000F0E (`pkt_len`=6) for bytes 0x01..0x03 and 0x0A..0x0F.
- `resetn` pulsed low after byte 2 of a 4-byte packet -> outputs go to their reset values immediately and no `wr_en` occurs for the discarded bytes; a following 4-byte packet 0x11..0x14 writes 0x14131211 with `pkt_len`=4.
